// File: rtl/mux_rr_scheduler_pkg.sv
// Shared constants and types for the round-robin gated-selector scheduler.
// State encoding is fixed so other arbiters in the slice can decode it.
package mux_rr_scheduler_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Request/data bundle from the sources and the registered selector/stream outputs.
// The scheduler uses the slave view; sources and the serial consumer use master.
interface mux_rr_scheduler_if;
    import mux_rr_scheduler_pkg::*;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] data;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  sel;
    logic              flag;
    logic              valid_data;
    logic              vld;
    logic              busy;

    modport master (
        output req, data,
        input  grant, sel, flag, valid_data, vld, busy
    );

    modport slave (
        input  req, data,
        output grant, sel, flag, valid_data, vld, busy
    );

endinterface

// File: rtl/mux_rr_scheduler_rr_pick4.sv
// Combinational 4-way round-robin picker: first set request after last_ptr, wrapping.
// last_ptr itself is searched last, so the previous owner has lowest priority.
module rr_pick4
    import mux_rr_scheduler_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last_ptr,
    output logic [SEL_W-1:0]  pick,
    output logic              any
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest candidate toward the nearest so the nearest hit wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = last_ptr + SEL_W'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving a 4-channel 1-bit gated selector and a registered
// serial output stream; each owner holds the selector for up to HOLD_LEN cycles.
module mux_rr_scheduler
    import mux_rr_scheduler_pkg::*;
#(
    parameter int HOLD_LEN = 4,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_rr_scheduler_if.slave    bus
);

    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_LEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  last_ptr_q, last_ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              flag_q, flag_d;
    logic              busy_q, busy_d;
    logic              valid_data_p0, valid_data_d;
    logic              vld_p0, vld_d;

    logic [SEL_W-1:0]  pick;
    logic              any;

    rr_pick4 u_pick (
        .req      (bus.req),
        .last_ptr (last_ptr_q),
        .pick     (pick),
        .any      (any)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_ptr_d   = last_ptr_q;
        sel_d        = sel_q;
        grant_d      = '0;
        flag_d       = 1'b0;
        valid_data_d = 1'b0;
        vld_d        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick;
                    grant_d = onehot(pick);
                    flag_d  = 1'b1;
                    cnt_d   = HOLD_CNT;
                end
            end
            ST_GRANT: begin
                // The release cycle still contributes its data bit to the stream.
                valid_data_d = bus.data[sel_q];
                vld_d        = 1'b1;
                if (cnt_q == '0 || !bus.req[sel_q]) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    grant_d = grant_q;
                    flag_d  = 1'b1;
                end
            end
            ST_GAP: begin
                last_ptr_d = sel_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_ptr_q <= SEL_W'(NUM_CH - 1);
            sel_q      <= '0;
            grant_q    <= '0;
            flag_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_ptr_q <= last_ptr_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            flag_q     <= flag_d;
            busy_q     <= busy_d;
        end
    end

    // Serial stream sample stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_data_p0 <= 1'b0;
            vld_p0        <= 1'b0;
        end else begin
            valid_data_p0 <= valid_data_d;
            vld_p0        <= vld_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.sel        = sel_q;
    assign bus.flag       = flag_q;
    assign bus.busy       = busy_q;
    assign bus.valid_data = valid_data_p0;
    assign bus.vld        = vld_p0;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: HOLD_LEN=4 instance plus a HOLD_LEN=1 instance.
module tb_mux_rr_scheduler;

    logic clk;
    logic rst_n;
    logic rst1_n;
    int   n_cmp;
    int   n_err;

    mux_rr_scheduler_if bus0 ();
    mux_rr_scheduler_if bus1 ();

    mux_rr_scheduler #(.HOLD_LEN(4), .CNT_W(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    mux_rr_scheduler #(.HOLD_LEN(1), .CNT_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view: {grant, sel, flag, vld, valid_data, busy}
    task automatic chk0(input string tag, input logic [3:0] g, input logic [1:0] s,
                        input logic f, input logic v, input logic vd, input logic b);
        chk(tag, {6'b0, bus0.grant, bus0.sel, bus0.flag, bus0.vld, bus0.valid_data, bus0.busy},
                 {6'b0, g, s, f, v, vd, b});
    endtask

    initial begin
        logic [3:0] seq;
        logic [3:0] g6 [7];
        logic       v6 [7];
        int         phase;
        int         ch;

        n_cmp = 0;
        n_err = 0;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        bus0.req  = 4'b1111;
        bus0.data = 4'b1111;
        bus1.req  = 4'b0000;
        bus1.data = 4'b0000;

        // Reset held with all channels requesting
        tick();
        tick();
        chk0("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // All requesting: 4-cycle grants, 6-cycle spacing, order 0,1,2,3,0
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            phase = (k - 1) % 6;
            ch    = ((k - 1) / 6) % 4;
            chk0($sformatf("all_req_k%0d", k),
                 (phase < 4) ? (4'b0001 << ch) : 4'b0000,
                 2'(ch),
                 phase < 4,
                 (phase >= 1) && (phase <= 4),
                 (phase >= 1) && (phase <= 4),
                 phase < 5);
        end

        // Single channel 2, data stream 1,0,1,1
        bus0.req  = 4'b0000;
        bus0.data = 4'b0000;
        tick();
        chk0("ch2_pre_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        seq = 4'b1101;
        bus0.req = 4'b0100;
        tick();
        chk0("ch2_grant", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus0.data = {1'b0, seq[i], 2'b00};
            tick();
            if (i < 3)
                chk0($sformatf("ch2_stream_%0d", i), 4'b0100, 2'd2, 1'b1, 1'b1, seq[i], 1'b1);
            else
                chk0("ch2_gap", 4'b0000, 2'd2, 1'b0, 1'b1, seq[i], 1'b1);
        end
        tick();
        chk0("ch2_idle", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk0("ch2_regrant", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        bus0.req = 4'b0000;
        tick();
        tick();
        chk0("ch2_drain", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Early release of channel 1 in its second grant cycle
        bus0.req  = 4'b0010;
        bus0.data = 4'b0010;
        tick();
        chk0("early_g1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk0("early_g2", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        bus0.req = 4'b0000;
        tick();
        chk0("early_gap", 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk0("early_idle", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the third grant cycle of channel 3
        bus0.req  = 4'b1000;
        bus0.data = 4'b1000;
        tick();
        tick();
        tick();
        chk0("ch3_cycle3", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk0("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus0.req = 4'b1001;
        tick();
        rst_n = 1'b1;
        tick();
        chk0("post_reset_ch0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        bus0.req = 4'b0000;
        tick();
        tick();

        // HOLD_LEN=1 instance, channels 1 and 3 alternating with a 3-cycle period
        g6 = '{4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0010};
        v6 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus1.req  = 4'b1010;
        bus1.data = 4'b1010;
        rst1_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("hold1_grant_%0d", k), {12'b0, bus1.grant}, {12'b0, g6[k]});
            chk($sformatf("hold1_vld_%0d", k), {15'b0, bus1.vld}, {15'b0, v6[k]});
            chk($sformatf("hold1_flag_%0d", k), {15'b0, bus1.flag}, {15'b0, |g6[k]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
